decode_stage: RTL and testbench

- Registered MIPS instruction-decode pipeline stage. It sits between the fetch stage and the execute stage.
- Splits the fetched word into fields and extends the immediate according to the opcode.
- Selects the destination register and generates the write and load flags.
- Detects load-use hazards and inserts bubbles. Supports a branch flush.
- Valid/ready handshake on both sides; one decoded instruction held in the output register.

---
 rtl/decode_stage_if.sv | 37 +++
 rtl/decode_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode_stage and execute.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_stage_if #(
   parameter int PC_WIDTH = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [31:0]         in_ir;
   logic [PC_WIDTH-1:0] in_pc;
   logic                flush;
   logic                ex_load;
   logic [4:0]          ex_rd;
   logic                out_valid;
   logic                out_ready;
   logic [5:0]          out_opcode;
   logic [4:0]          out_rs;
   logic [4:0]          out_rt;
   logic [4:0]          out_rd;
   logic [4:0]          out_shamt;
   logic [5:0]          out_funct;
   logic [31:0]         out_imm;
   logic [PC_WIDTH-1:0] out_pc;
   logic                out_we;
   logic                out_mem_read;

   modport slave (
      input  in_valid, in_ir, in_pc, flush, ex_load, ex_rd, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_pc, out_we, out_mem_read
   );

   modport master (
      output in_valid, in_ir, in_pc, flush, ex_load, ex_rd, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd,
             out_shamt, out_funct, out_imm, out_pc, out_we, out_mem_read
   );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS decode stage with load-use bubble insertion and branch flush.
// Optional DECODE_STATS_EN adds saturating stall/flush event counters.
module decode_stage #(
   parameter int PC_WIDTH = 32,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   decode_stage_if.slave     bus
`ifdef DECODE_STATS_EN
   ,
   output logic [15:0]       stall_count,
   output logic [15:0]       flush_count
`endif
);

   logic [5:0]          opcode;
   logic [5:0]          funct;
   logic [4:0]          rs;
   logic [4:0]          rt;
   logic [4:0]          rd_dec;
   logic [31:0]         imm_dec;
   logic                mem_read_dec;
   logic                we_dec;
   logic                hazard;
   logic                advance;
   logic                accept;

   logic                valid_d,    valid_q;
   logic [5:0]          opcode_d,   opcode_q;
   logic [4:0]          rs_d,       rs_q;
   logic [4:0]          rt_d,       rt_q;
   logic [4:0]          rd_d,       rd_q;
   logic [4:0]          shamt_d,    shamt_q;
   logic [5:0]          funct_d,    funct_q;
   logic [31:0]         imm_d,      imm_q;
   logic [PC_WIDTH-1:0] pc_d,       pc_q;
   logic                we_d,       we_q;
   logic                mem_read_d, mem_read_q;

   assign opcode = bus.in_ir[31:26];
   assign funct  = bus.in_ir[5:0];
   assign rs     = bus.in_ir[25:21];
   assign rt     = bus.in_ir[20:16];

   always_comb begin
      rd_dec       = rt;
      imm_dec      = {{16{bus.in_ir[15]}}, bus.in_ir[15:0]};
      mem_read_dec = 1'b0;
      we_dec       = 1'b0;

      if (opcode == 6'h00)      rd_dec = bus.in_ir[15:11];
      else if (opcode == 6'h03) rd_dec = 5'(LINK_REG);

      case (opcode)
         6'h0C, 6'h0D, 6'h0E: imm_dec = {16'h0000, bus.in_ir[15:0]};
         6'h0F:               imm_dec = {bus.in_ir[15:0], 16'h0000};
         default:             imm_dec = {{16{bus.in_ir[15]}}, bus.in_ir[15:0]};
      endcase

      case (opcode)
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: mem_read_dec = 1'b1;
         default:                           mem_read_dec = 1'b0;
      endcase

      we_dec = ((opcode == 6'h00) && (funct != 6'h08)) || mem_read_dec ||
               (opcode[5:3] == 3'b001) || (opcode == 6'h03);
      // Writes to $zero are architecturally dead; suppress them here.
      if (rd_dec == 5'd0) we_dec = 1'b0;
   end

   // rt is compared for every opcode: conservative, never misses a real hazard.
   assign hazard  = bus.ex_load && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == rs) || (bus.ex_rd == rt));
   assign advance = !valid_q || bus.out_ready;
   assign accept  = advance && bus.in_valid && !hazard && !bus.flush;
   assign bus.in_ready = advance && !hazard && !bus.flush;

   always_comb begin
      valid_d    = valid_q;
      opcode_d   = opcode_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      shamt_d    = shamt_q;
      funct_d    = funct_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      we_d       = we_q;
      mem_read_d = mem_read_q;

      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d    = 1'b1;
         opcode_d   = opcode;
         rs_d       = rs;
         rt_d       = rt;
         rd_d       = rd_dec;
         shamt_d    = bus.in_ir[10:6];
         funct_d    = funct;
         imm_d      = imm_dec;
         pc_d       = bus.in_pc;
         we_d       = we_dec;
         mem_read_d = mem_read_dec;
      end else if (advance) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         opcode_q   <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         shamt_q    <= '0;
         funct_q    <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         we_q       <= 1'b0;
         mem_read_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         opcode_q   <= opcode_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         shamt_q    <= shamt_d;
         funct_q    <= funct_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         we_q       <= we_d;
         mem_read_q <= mem_read_d;
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_opcode   = opcode_q;
   assign bus.out_rs       = rs_q;
   assign bus.out_rt       = rt_q;
   assign bus.out_rd       = rd_q;
   assign bus.out_shamt    = shamt_q;
   assign bus.out_funct    = funct_q;
   assign bus.out_imm      = imm_q;
   assign bus.out_pc       = pc_q;
   assign bus.out_we       = we_q;
   assign bus.out_mem_read = mem_read_q;

`ifdef DECODE_STATS_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;
   logic [15:0] flush_cnt_d, flush_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.in_valid && hazard && advance && !bus.flush && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (bus.flush && (flush_cnt_q != 16'hFFFF))
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field/immediate decode, hazard bubbles,
// backpressure, flush and asynchronous reset, checked against hand values.
module tb_decode_stage;

   logic clk;
   logic rst_n;
   int   compares = 0;
   int   fails    = 0;

   decode_stage_if #(.PC_WIDTH(32)) bus ();

`ifdef DECODE_STATS_EN
   logic [15:0] stall_count;
   logic [15:0] flush_count;
`endif

   decode_stage #(.PC_WIDTH(32), .LINK_REG(31)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus)
`ifdef DECODE_STATS_EN
      ,
      .stall_count (stall_count),
      .flush_count (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] ir, input logic [31:0] pc);
      bus.in_valid = 1'b1;
      bus.in_ir    = ir;
      bus.in_pc    = pc;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_ir     = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.ex_load   = 1'b0;
      bus.ex_rd     = '0;
      bus.out_ready = 1'b1;

      #12;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_imm", bus.out_imm, 32'd0);
      chk("rst_we", 32'(bus.out_we), 32'd0);
      #5 rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // R-type add $3,$1,$2
      tick();
      present(32'h00221820, 32'h100);
      tick();
      chk("r_valid", 32'(bus.out_valid), 32'd1);
      chk("r_rs", 32'(bus.out_rs), 32'd1);
      chk("r_rt", 32'(bus.out_rt), 32'd2);
      chk("r_rd", 32'(bus.out_rd), 32'd3);
      chk("r_funct", 32'(bus.out_funct), 32'h20);
      chk("r_we", 32'(bus.out_we), 32'd1);
      chk("r_memrd", 32'(bus.out_mem_read), 32'd0);
      chk("r_pc", bus.out_pc, 32'h100);

      present(32'h3405FFFF, 32'h104);
      tick();
      chk("ori_imm", bus.out_imm, 32'h0000FFFF);
      chk("ori_rd", 32'(bus.out_rd), 32'd5);
      chk("ori_we", 32'(bus.out_we), 32'd1);

      present(32'h3C041234, 32'h108);
      tick();
      chk("lui_imm", bus.out_imm, 32'h12340000);
      chk("lui_rd", 32'(bus.out_rd), 32'd4);

      present(32'h2006FFFF, 32'h10C);
      tick();
      chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
      chk("addi_we", 32'(bus.out_we), 32'd1);

      present(32'h0C000010, 32'h110);
      tick();
      chk("jal_rd", 32'(bus.out_rd), 32'd31);
      chk("jal_we", 32'(bus.out_we), 32'd1);
      chk("jal_opcode", 32'(bus.out_opcode), 32'h03);

      present(32'h00200020, 32'h114);
      tick();
      chk("rd0_rd", 32'(bus.out_rd), 32'd0);
      chk("rd0_we", 32'(bus.out_we), 32'd0);

      present(32'h03E00008, 32'h118);
      tick();
      chk("jr_valid", 32'(bus.out_valid), 32'd1);
      chk("jr_rs", 32'(bus.out_rs), 32'd31);
      chk("jr_we", 32'(bus.out_we), 32'd0);

      // lw $3,4($2)
      present(32'h8C430004, 32'h11C);
      tick();
      chk("lw_memrd", 32'(bus.out_mem_read), 32'd1);
      chk("lw_we", 32'(bus.out_we), 32'd1);
      chk("lw_rd", 32'(bus.out_rd), 32'd3);
      chk("lw_imm", bus.out_imm, 32'd4);

      // load to $zero never creates a hazard
      bus.ex_load = 1'b1;
      bus.ex_rd   = 5'd0;
      present(32'h00001820, 32'h1FC);
      #1;
      chk("haz_rd0_ready", 32'(bus.in_ready), 32'd1);

      // load-use stall
      bus.ex_rd = 5'd2;
      present(32'h00221820, 32'h200);
      #1;
      chk("haz_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("haz_bubble", 32'(bus.out_valid), 32'd0);
      bus.ex_load = 1'b0;
      #1;
      chk("haz_clear_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("haz_acc_valid", 32'(bus.out_valid), 32'd1);
      chk("haz_acc_pc", bus.out_pc, 32'h200);
`ifdef DECODE_STATS_EN
      chk("stall_count", 32'(stall_count), 32'd1);
`endif

      // backpressure
      bus.out_ready = 1'b0;
      present(32'h3405FFFF, 32'h300);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_pc", bus.out_pc, 32'h200);
         chk("bp_rd", 32'(bus.out_rd), 32'd3);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_pc", bus.out_pc, 32'h300);
      chk("bp_release_imm", bus.out_imm, 32'h0000FFFF);

      // flush
      bus.flush = 1'b1;
      present(32'h00221820, 32'h304);
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
`ifdef DECODE_STATS_EN
      chk("flush_count", 32'(flush_count), 32'd1);
`endif
      bus.flush = 1'b0;

      // async reset between edges
      present(32'h00221820, 32'h400);
      tick();
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_pc", bus.out_pc, 32'd0);
      chk("arst_rd", 32'(bus.out_rd), 32'd0);
      chk("arst_imm", bus.out_imm, 32'd0);
      chk("arst_we", 32'(bus.out_we), 32'd0);
      #1 rst_n = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
